tqv_bus_initiator: RTL and testbench

// - Burst bus initiator for the TinyQV peripheral data interface (data_write_n/data_read_n/data_ready).
// - Accepts a command (op, size, start address, beat count), then issues that many sequential
//   8/16/32-bit transactions to one responder, e.g. the latch RAM.
// - Streams write data in and read data out through valid/ready handshakes.
// - Used for self-test, RAM preload and DMA-style copies without core involvement.

---
 rtl/tqv_bus_initiator.sv | 234 +++++++++++++++++++++++
 tb/tb_tqv_bus_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_bus_initiator.sv
// Burst bus initiator for the TinyQV peripheral data interface (8/16/32-bit beats, wrapping address).
// Optional request timeout enabled by defining TQV_INIT_TIMEOUT_EN.
module tqv_bus_initiator #(
    parameter int unsigned ADDR_BITS  = 5,
    parameter int unsigned COUNT_BITS = 4
`ifdef TQV_INIT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_size,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [COUNT_BITS-1:0] cmd_count,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_data,
    output logic [ADDR_BITS-1:0]  addr_out,
    output logic [31:0]           data_out,
    output logic [1:0]            data_write_n,
    output logic [1:0]            data_read_n,
    input  logic [31:0]           data_in,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  error
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam logic [SIZE_W-1:0] REQ_IDLE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_REQ, S_RHOLD} state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [COUNT_BITS-1:0] beat_q, beat_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [SIZE_W-1:0]     write_n_q, write_n_d;
    logic [SIZE_W-1:0]     read_n_q, read_n_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  busy_q, busy_d;

    logic accept_c, wr_hs_c, done_c, rd_hs_c, last_c, advance_c, timeout_c;
    logic [DATA_W-1:0]    rd_masked_c;
    logic [ADDR_BITS-1:0] step_c;

    assign accept_c  = (state_q == S_IDLE) && cmd_valid;
    assign wr_hs_c   = (state_q == S_WDATA) && wr_valid;
    assign done_c    = (state_q == S_REQ) && data_ready;
    assign rd_hs_c   = (state_q == S_RHOLD) && rd_ready;
    assign last_c    = (beat_q == count_q);
    assign advance_c = (done_c && write_q) || rd_hs_c;
    assign step_c    = ADDR_BITS'(1) << size_q;

    always_comb begin
        unique case (size_q)
            2'b00:   rd_masked_c = {24'h0, data_in[7:0]};
            2'b01:   rd_masked_c = {16'h0, data_in[15:0]};
            default: rd_masked_c = data_in;
        endcase
    end

`ifdef TQV_INIT_TIMEOUT_EN
    // Counts request cycles without data_ready; expiry aborts the burst.
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign timeout_c = (state_q == S_REQ) && !data_ready
                       && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if ((state_q == S_REQ) && !data_ready && !timeout_c) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        err_d = err_q;
        if (accept_c) begin
            err_d = 1'b0;
        end
        if (timeout_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign error = err_q;
`else
    assign timeout_c = 1'b0;
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? S_WDATA : S_REQ;
                end
            end
            S_WDATA: begin
                if (wr_valid) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (timeout_c) begin
                    state_d = S_IDLE;
                end else if (data_ready) begin
                    state_d = !write_q ? S_RHOLD : (last_c ? S_IDLE : S_WDATA);
                end
            end
            S_RHOLD: begin
                if (rd_ready) begin
                    state_d = last_c ? S_IDLE : S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for all registered outputs and burst context; bus outputs follow state_d.
    always_comb begin
        write_d    = write_q;
        size_d     = size_q;
        count_d    = count_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        data_out_d = data_out_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        if (accept_c) begin
            write_d = cmd_write;
            size_d  = (cmd_size == 2'b11) ? 2'b10 : cmd_size;
            count_d = cmd_count;
            beat_d  = '0;
            addr_d  = cmd_addr;
        end
        if (wr_hs_c) begin
            data_out_d = wr_data;
        end
        if (done_c && !write_q) begin
            rd_data_d  = rd_masked_c;
            rd_valid_d = 1'b1;
        end
        if (rd_hs_c) begin
            rd_valid_d = 1'b0;
        end
        if (advance_c && !last_c) begin
            addr_d = addr_q + step_c;
            beat_d = beat_q + COUNT_BITS'(1);
        end

        cmd_ready_d = (state_d == S_IDLE);
        wr_ready_d  = (state_d == S_WDATA);
        busy_d      = (state_d != S_IDLE);
        write_n_d   = ((state_d == S_REQ) && write_d)  ? size_d : REQ_IDLE;
        read_n_d    = ((state_d == S_REQ) && !write_d) ? size_d : REQ_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q     <= 1'b0;
            size_q      <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            data_out_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            write_n_q   <= REQ_IDLE;
            read_n_q    <= REQ_IDLE;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            write_q     <= write_d;
            size_q      <= size_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            data_out_q  <= data_out_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            write_n_q   <= write_n_d;
            read_n_q    <= read_n_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign wr_ready     = wr_ready_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign addr_out     = addr_q;
    assign data_out     = data_out_q;
    assign data_write_n = write_n_q;
    assign data_read_n  = read_n_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_tqv_bus_initiator.sv
// Bench for tqv_bus_initiator: table of directed bursts against a byte-RAM responder model,
// plus hand sequences for mid-burst reset and (when TQV_INIT_TIMEOUT_EN is defined) timeout.
module tb_tqv_bus_initiator;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned NV = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [1:0]    cmd_size;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] cmd_count;
    logic          wr_valid, wr_ready;
    logic [31:0]   wr_data;
    logic          rd_valid, rd_ready;
    logic [31:0]   rd_data;
    logic [AW-1:0] addr_out;
    logic [31:0]   data_out;
    logic [1:0]    data_write_n, data_read_n;
    logic [31:0]   data_in;
    logic          data_ready = 1'b0;
    logic          busy, error;

    always #5 clk = ~clk;

    tqv_bus_initiator dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .addr_out(addr_out), .data_out(data_out),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_in(data_in), .data_ready(data_ready),
        .busy(busy), .error(error)
    );

    typedef struct packed {
        logic          write;
        logic [1:0]    size;
        logic [4:0]    addr;
        logic [3:0]    count;
        logic [7:0]    delay;
        logic [7:0]    stall_beat;
        logic [7:0]    rd_hold;
        logic [3:0][31:0] data;
        logic [3:0][4:0]  exp_addr;
        logic [3:0][31:0] exp_rd;
    } vec_t;

    vec_t vecs [NV];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Responder model: byte RAM, completes each request after resp_delay cycles.
    logic [7:0]  ram [32];
    int          resp_delay = 1;
    int          act_cnt = 0;
    logic [1:0]  cur_code = 2'b00;
    logic        cur_write = 1'b0;
    bit          prev_done = 1'b0;
    logic [4:0]  prev_addr = '0;
    logic [4:0]  obs_addr [$];
    logic [31:0] obs_data [$];
    int          obs_len  [$];
    logic        req_active;

    assign req_active = (data_write_n != 2'b11) || (data_read_n != 2'b11);

    always_comb begin
        data_in = {ram[addr_out + 5'd3], ram[addr_out + 5'd2], ram[addr_out + 5'd1], ram[addr_out]};
    end

    function automatic logic [31:0] ram_word(input logic [4:0] a);
        return {ram[a + 5'd3], ram[a + 5'd2], ram[a + 5'd1], ram[a]};
    endfunction

    always @(negedge clk) begin
        if (rst || !req_active) begin
            act_cnt    = 0;
            data_ready = 1'b0;
            prev_done  = 1'b0;
        end else begin
            act_cnt++;
            data_ready = (act_cnt >= resp_delay);
            chk("req_code", 32'({data_write_n, data_read_n}),
                32'(cur_write ? {cur_code, 2'b11} : {2'b11, cur_code}));
            chk("req_gap", 32'(prev_done), 32'd0);
            if (act_cnt > 1) chk("addr_hold", 32'(addr_out), 32'(prev_addr));
            prev_addr = addr_out;
            prev_done = data_ready;
            if (data_ready) begin
                obs_addr.push_back(addr_out);
                obs_data.push_back(data_out);
                obs_len.push_back(act_cnt);
                if (cur_write) begin
                    for (int k = 0; k < (1 << cur_code); k++) begin
                        ram[5'(32'(addr_out) + k)] = data_out[8*k +: 8];
                    end
                end
            end
        end
    end

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic [4:0] a,
                                input logic [3:0] c, input logic [7:0] dly,
                                input logic [7:0] stall, input logic [7:0] hold);
        vec_t v;
        v = '0;
        v.write = w; v.size = s; v.addr = a; v.count = c;
        v.delay = dly; v.stall_beat = stall; v.rd_hold = hold;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        int          g;
        logic [1:0]  code;
        logic [31:0] held;
        logic [31:0] mask;
        n    = int'(v.count) + 1;
        code = (v.size == 2'b11) ? 2'b10 : v.size;
        mask = (code == 2'b00) ? 32'hFF : (code == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        obs_addr.delete(); obs_data.delete(); obs_len.delete();
        resp_delay = int'(v.delay);
        cur_code   = code;
        cur_write  = v.write;

        @(negedge clk);
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        chk($sformatf("v%0d cmd_ready", idx), 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_size = v.size;
        cmd_addr = v.addr; cmd_count = v.count;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        if (!v.write) chk($sformatf("v%0d rd_req_lat", idx), 32'(data_read_n), 32'(code));

        for (int b = 0; b < n; b++) begin
            if (v.write) begin
                if (b == int'(v.stall_beat)) begin
                    g = 0;
                    while (!wr_ready && g < 50) begin @(negedge clk); g++; end
                    repeat (3) begin
                        @(negedge clk);
                        chk($sformatf("v%0d stall_wr_ready", idx), 32'(wr_ready), 32'd1);
                        chk($sformatf("v%0d stall_req", idx), 32'(data_write_n), 32'd3);
                    end
                end
                wr_valid = 1'b1;
                wr_data  = v.data[b];
                g = 0;
                while (!wr_ready && g < 50) begin @(negedge clk); g++; end
                chk($sformatf("v%0d wr_ready_wait", idx), 32'(wr_ready), 32'd1);
                @(posedge clk); #1;
                wr_valid = 1'b0;
                chk($sformatf("v%0d wr_req_lat", idx), 32'(data_write_n), 32'(code));
            end else begin
                g = 0;
                while (!rd_valid && g < 100) begin @(negedge clk); g++; end
                chk($sformatf("v%0d rd_valid_wait", idx), 32'(rd_valid), 32'd1);
                chk($sformatf("v%0d rd_data%0d", idx, b), rd_data, v.exp_rd[b]);
                held = rd_data;
                repeat (int'(v.rd_hold)) begin
                    @(negedge clk);
                    chk($sformatf("v%0d hold_valid", idx), 32'(rd_valid), 32'd1);
                    chk($sformatf("v%0d hold_data", idx), rd_data, held);
                    chk($sformatf("v%0d hold_req", idx), 32'(data_read_n), 32'd3);
                end
                rd_ready = 1'b1;
                @(posedge clk); #1;
                rd_ready = 1'b0;
                chk($sformatf("v%0d rd_valid_clr", idx), 32'(rd_valid), 32'd0);
                if (b < n - 1) chk($sformatf("v%0d rd_next_req", idx), 32'(data_read_n), 32'(code));
            end
        end

        g = 0;
        while (busy && g < 50) begin @(negedge clk); g++; end
        chk($sformatf("v%0d idle", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d cmd_ready_idle", idx), 32'(cmd_ready), 32'd1);
        chk($sformatf("v%0d error", idx), 32'(error), 32'd0);
        chk($sformatf("v%0d beats", idx), 32'(obs_addr.size()), 32'(n));
        for (int b = 0; b < n && b < obs_addr.size(); b++) begin
            chk($sformatf("v%0d addr%0d", idx, b), 32'(obs_addr[b]), 32'(v.exp_addr[b]));
            chk($sformatf("v%0d len%0d", idx, b), 32'(obs_len[b]), 32'(v.delay));
            if (v.write) chk($sformatf("v%0d data_out%0d", idx, b), obs_data[b], v.data[b]);
        end
        if (v.write) begin
            chk($sformatf("v%0d ram", idx), ram_word(v.exp_addr[n-1]) & mask, v.data[n-1] & mask);
        end
    endtask

    initial begin
        int g;
        int cnt;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = '0; cmd_count = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        ram[30] = 8'h11; ram[31] = 8'h22; ram[0] = 8'h33; ram[1] = 8'h44;
        ram[8] = 8'h01; ram[9] = 8'h02; ram[10] = 8'h03; ram[11] = 8'h04;

        // write, size 32, addr 4, one beat, responder ready after 4 cycles
        vecs[0] = mk(1'b1, 2'b10, 5'd4, 4'd0, 8'd4, 8'hFF, 8'd0);
        vecs[0].data[0] = 32'hDEADBEEF; vecs[0].exp_addr[0] = 5'd4;
        // read, size 8, addr 30, four beats wrapping
        vecs[1] = mk(1'b0, 2'b00, 5'd30, 4'd3, 8'd2, 8'hFF, 8'd0);
        vecs[1].exp_addr[0] = 5'd30; vecs[1].exp_addr[1] = 5'd31;
        vecs[1].exp_addr[2] = 5'd0;  vecs[1].exp_addr[3] = 5'd1;
        vecs[1].exp_rd[0] = 32'h11; vecs[1].exp_rd[1] = 32'h22;
        vecs[1].exp_rd[2] = 32'h33; vecs[1].exp_rd[3] = 32'h44;
        // read, size 16, two beats, rd_ready withheld 5 cycles
        vecs[2] = mk(1'b0, 2'b01, 5'd8, 4'd1, 8'd1, 8'hFF, 8'd5);
        vecs[2].exp_addr[0] = 5'd8; vecs[2].exp_addr[1] = 5'd10;
        vecs[2].exp_rd[0] = 32'h0201; vecs[2].exp_rd[1] = 32'h0403;
        // write, size 32, three beats, wr_valid withheld before beat 2
        vecs[3] = mk(1'b1, 2'b10, 5'd12, 4'd2, 8'd2, 8'd2, 8'd0);
        vecs[3].data[0] = 32'h11111111; vecs[3].data[1] = 32'h22222222; vecs[3].data[2] = 32'h33333333;
        vecs[3].exp_addr[0] = 5'd12; vecs[3].exp_addr[1] = 5'd16; vecs[3].exp_addr[2] = 5'd20;
        // write, size code 11 behaves as 32-bit, address wraps 31 -> 3
        vecs[4] = mk(1'b1, 2'b11, 5'd31, 4'd1, 8'd1, 8'hFF, 8'd0);
        vecs[4].data[0] = 32'hA5A50001; vecs[4].data[1] = 32'h5A5A0002;
        vecs[4].exp_addr[0] = 5'd31; vecs[4].exp_addr[1] = 5'd3;
        // write, size 8, unaligned start
        vecs[5] = mk(1'b1, 2'b00, 5'd7, 4'd1, 8'd3, 8'hFF, 8'd0);
        vecs[5].data[0] = 32'hFFFFFF77; vecs[5].data[1] = 32'h00000088;
        vecs[5].exp_addr[0] = 5'd7; vecs[5].exp_addr[1] = 5'd8;
        // read back a word written by vector 3
        vecs[6] = mk(1'b0, 2'b10, 5'd12, 4'd0, 8'd1, 8'hFF, 8'd0);
        vecs[6].exp_addr[0] = 5'd12; vecs[6].exp_rd[0] = 32'h11111111;

        repeat (2) @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst wr_ready", 32'(wr_ready), 32'd0);
        chk("rst rd_valid", 32'(rd_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        chk("rst req", 32'({data_write_n, data_read_n}), 32'hF);
        chk("rst addr_out", 32'(addr_out), 32'd0);
        chk("rst data_out", data_out, 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset asserted during the request of beat 1 of a 4-beat read
        resp_delay = 3; cur_code = 2'b00; cur_write = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = 5'd30; cmd_count = 4'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        g = 0;
        while (!rd_valid && g < 50) begin @(negedge clk); g++; end
        chk("mr beat0", rd_data, 32'h11);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        chk("mr beat1 req", 32'(data_read_n), 32'd0);
        chk("mr beat1 addr", 32'(addr_out), 32'd31);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mr req", 32'({data_write_n, data_read_n}), 32'hF);
        chk("mr busy", 32'(busy), 32'd0);
        chk("mr cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mr rd_valid", 32'(rd_valid), 32'd0);
        chk("mr addr_out", 32'(addr_out), 32'd0);
        chk("mr rd_data", rd_data, 32'd0);
        chk("mr error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef TQV_INIT_TIMEOUT_EN
        // Responder never ready: request held 15 cycles, then abort with error
        resp_delay = 1000; cur_code = 2'b01; cur_write = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b01; cmd_addr = 5'd0; cmd_count = 4'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cnt = 0; g = 0;
        while (data_read_n != 2'b11 && g < 60) begin
            @(negedge clk);
            if (data_read_n != 2'b11) cnt++;
            g++;
        end
        chk("to req cycles", 32'(cnt), 32'd15);
        chk("to error", 32'(error), 32'd1);
        chk("to busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("to no rd_valid", 32'(rd_valid), 32'd0);
            chk("to stays idle", 32'(data_read_n), 32'd3);
        end
`endif

        // New command after reset (and after a timeout, clears error)
        run_vec(6, vecs[6]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
